dmem_responder: RTL and testbench

- Memory-side responder for the CPU data port: the CPU supplies address (ALU result), store data (rs2 value) and control; this block returns Data_in.
- Holds a word-organised data RAM plus two MMIO words, with configurable wait states and a valid/ready handshake so the CPU can stall.
- Handles byte, half-word and word accesses, alignment checks and load extension.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_unit.sv | 45 ++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory responder.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam int unsigned CNT_W = 4;

   localparam logic [31:0] MMIO_OUT_OFS = 32'd0;
   localparam logic [31:0] MMIO_IN_OFS  = 32'd4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: store merge, load extraction/extension and alignment check.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_raw_i,
   output logic [31:0] wword_o,
   output logic [31:0] load_o,
   output logic        misalign_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata_raw_i >> {addr_lo_i, 3'b000};
      wword_o = old_word_i;
      load_o  = '0;
      case (size_i)
         SZ_B: begin
            wword_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            load_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            wword_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            load_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         end
         SZ_W: begin
            wword_o = wdata_i;
            load_o  = rdata_raw_i;
         end
         default: begin
            wword_o = old_word_i;
            load_o  = '0;
         end
      endcase
   end

   assign misalign_o = ((size_i == SZ_H) && addr_lo_i[0]) ||
                       ((size_i == SZ_W) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: word RAM plus two MMIO words behind a valid/ready handshake
// with a programmable number of wait states between acceptance and response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] MMIO_BASE   = 32'hF000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mmio_out,
   input  logic [31:0] mmio_in
);

   localparam int unsigned       AW       = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0]  CntLoad  = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [31:0]       OutAddr  = MMIO_BASE + MMIO_OUT_OFS;
   localparam logic [31:0]       InAddr   = MMIO_BASE + MMIO_IN_OFS;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdy_q;
   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic [31:0]       addr_q, wdata_q;
   logic [31:0]       resp_rdata_q, mmio_q;
   logic              resp_err_q;
   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              accept, commit, err;
   logic              cur_we, cur_uns;
   logic [1:0]        cur_size;
   logic [31:0]       cur_addr, cur_wdata;
   logic [AW-1:0]     word_idx;
   logic              hit_ram, hit_out, hit_in, misalign;
   logic [31:0]       sel_word, wword, load_word;

   // rdy_q keeps req_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntLoad;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) state_d = StResp;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = rdy_q && (state_q == StIdle);
      resp_valid = (state_q == StResp);
      resp_rdata = resp_rdata_q;
      resp_err   = resp_err_q;
      mmio_out   = mmio_q;
   end

   assign accept = req_valid && req_ready;
   assign commit = (state_d == StResp) && (state_q != StResp);

   // With zero wait states the commit edge is the acceptance edge, so use live inputs in IDLE
   always_comb begin
      if (state_q == StIdle) begin
         cur_we    = req_we;
         cur_uns   = req_unsigned;
         cur_size  = req_size;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
      end else begin
         cur_we    = we_q;
         cur_uns   = uns_q;
         cur_size  = size_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
   end

   always_comb begin
      word_idx = cur_addr[AW+1:2];
      hit_ram  = (cur_addr[31:AW+2] == '0);
      hit_out  = (cur_addr[31:2] == OutAddr[31:2]);
      hit_in   = (cur_addr[31:2] == InAddr[31:2]);
      if (hit_ram)      sel_word = mem_q[word_idx];
      else if (hit_out) sel_word = mmio_q;
      else if (hit_in)  sel_word = mmio_in;
      else              sel_word = '0;
      err = (cur_size == 2'b11) || misalign || !(hit_ram || hit_out || hit_in) ||
            (cur_we && hit_in);
   end

   dmem_lane_unit u_lane (
      .size_i      (cur_size),
      .addr_lo_i   (cur_addr[1:0]),
      .unsigned_i  (cur_uns),
      .old_word_i  (sel_word),
      .wdata_i     (cur_wdata),
      .rdata_raw_i (sel_word),
      .wword_o     (wword),
      .load_o      (load_word),
      .misalign_o  (misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         size_q       <= SZ_B;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mmio_q       <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            resp_rdata_q <= (err || cur_we) ? '0 : load_word;
            resp_err_q   <= err;
            if (cur_we && !err && hit_out) mmio_q <= wword;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit && cur_we && !err && hit_ram) mem_q[word_idx] <= wword;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of sequential accesses plus handshake/reset sequences.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned WAIT = 2;
   localparam logic [31:0] MB   = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, mmio_out, mmio_in;

   int n_checks = 0;
   int n_err    = 0;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (WAIT),
      .MMIO_BASE   (MB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mmio_out     (mmio_out),
      .mmio_in      (mmio_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] min;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] mmio;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] min,
                      input logic [31:0] rdata, input logic err, input logic [31:0] mmio);
      vec_t v;
      v.name = name; v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.min = min; v.rdata = rdata; v.err = err; v.mmio = mmio;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // lat counts rising edges from the acceptance edge up to the one that raises resp_valid
   task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] min, output logic [31:0] rd, output logic er,
                            output int lat, output logic [31:0] mmio_pre,
                            output logic [31:0] mmio_resp);
      int w;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; mmio_in = min; resp_ready = 1'b1;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      mmio_pre = mmio_out;
      @(posedge clk);
      lat = 1;
      #1;
      req_valid = 1'b0;
      while (!resp_valid && lat < 20) begin
         mmio_pre = mmio_out;
         @(posedge clk);
         lat++;
         #1;
      end
      rd = resp_rdata;
      er = resp_err;
      mmio_resp = mmio_out;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd, mpre, mresp, prev_mmio, held;
      logic        er;
      int          lat, n;

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1; mmio_in = '0;

      #2;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mmio_out", mmio_out, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready_clocked", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      add("sw_10",      1, SZ_W, 0, 32'h10,       32'h8000_00F0, 0, 32'h0,         0, 32'h0);
      add("lw_10",      0, SZ_W, 0, 32'h10,       0,             0, 32'h8000_00F0, 0, 32'h0);
      add("sb_11",      1, SZ_B, 0, 32'h11,       32'hFFFF_FFAB, 0, 32'h0,         0, 32'h0);
      add("lb_11",      0, SZ_B, 0, 32'h11,       0,             0, 32'hFFFF_FFAB, 0, 32'h0);
      add("lbu_11",     0, SZ_B, 1, 32'h11,       0,             0, 32'h0000_00AB, 0, 32'h0);
      add("lw_10_b",    0, SZ_W, 0, 32'h10,       0,             0, 32'h8000_ABF0, 0, 32'h0);
      add("lh_13_mis",  0, SZ_H, 0, 32'h13,       0,             0, 32'h0,         1, 32'h0);
      add("sw_12_mis",  1, SZ_W, 0, 32'h12,       32'h1,         0, 32'h0,         1, 32'h0);
      add("lw_10_c",    0, SZ_W, 0, 32'h10,       0,             0, 32'h8000_ABF0, 0, 32'h0);
      add("size11",     0, 2'b11, 0, 32'h10,      0,             0, 32'h0,         1, 32'h0);
      add("sh_12",      1, SZ_H, 0, 32'h12,       32'h1234_CAFE, 0, 32'h0,         0, 32'h0);
      add("lh_12",      0, SZ_H, 0, 32'h12,       0,             0, 32'hFFFF_CAFE, 0, 32'h0);
      add("lhu_12",     0, SZ_H, 1, 32'h12,       0,             0, 32'h0000_CAFE, 0, 32'h0);
      add("lb_12",      0, SZ_B, 0, 32'h12,       0,             0, 32'hFFFF_FFFE, 0, 32'h0);
      add("lw_10_uns",  0, SZ_W, 1, 32'h10,       0,             0, 32'hCAFE_ABF0, 0, 32'h0);
      add("lh_10",      0, SZ_H, 0, 32'h10,       0,             0, 32'hFFFF_ABF0, 0, 32'h0);
      add("sw_ffc",     1, SZ_W, 0, 32'hFFC,      32'hA5A5_0001, 0, 32'h0,         0, 32'h0);
      add("lw_ffc",     0, SZ_W, 0, 32'hFFC,      0,             0, 32'hA5A5_0001, 0, 32'h0);
      add("lw_unmap",   0, SZ_W, 0, 32'h1000,     0,             0, 32'h0,         1, 32'h0);
      add("sw_mmio",    1, SZ_W, 0, MB,           32'h1234_5678, 0, 32'h0,         0, 32'h1234_5678);
      add("lw_mmio_in", 0, SZ_W, 0, MB + 4,       0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h1234_5678);
      add("sw_mmio_in", 1, SZ_W, 0, MB + 4,       32'h5,         0, 32'h0,         1, 32'h1234_5678);
      add("lb_mmio_1",  0, SZ_B, 0, MB + 1,       0,             0, 32'h0000_0056, 0, 32'h1234_5678);
      add("lh_mmio_6",  0, SZ_H, 0, MB + 6,       0, 32'hDEAD_BEEF, 32'hFFFF_DEAD, 0, 32'h1234_5678);
      add("sb_mmio_3",  1, SZ_B, 0, MB + 3,       32'h99,        0, 32'h0,         0, 32'h9934_5678);
      add("lw_mmio",    0, SZ_W, 0, MB,           0,             0, 32'h9934_5678, 0, 32'h9934_5678);
      add("lw_mmio_8",  0, SZ_W, 0, MB + 8,       0,             0, 32'h0,         1, 32'h9934_5678);
      add("lw_mmio_2",  0, SZ_W, 0, MB + 2,       0,             0, 32'h0,         1, 32'h9934_5678);

      prev_mmio = 32'h0;
      foreach (vecs[i]) begin
         do_access(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   vecs[i].min, rd, er, lat, mpre, mresp);
         chk({vecs[i].name, "_latency"}, lat, WAIT + 1);
         chk({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
         chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].err});
         chk({vecs[i].name, "_mmio_before_commit"}, mpre, prev_mmio);
         chk({vecs[i].name, "_mmio_at_resp"}, mresp, vecs[i].mmio);
         prev_mmio = vecs[i].mmio;
      end

      // Hold resp_ready low; a store presented meanwhile must be ignored
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h10; resp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_we = 1'b1; req_wdata = 32'h0;
      n = 1;
      while (!resp_valid && n < 20) begin
         @(posedge clk);
         n++;
         #1;
      end
      chk("hold_latency", n, WAIT + 1);
      held = resp_rdata;
      chk("hold_rdata", held, 32'hCAFE_ABF0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("hold_rdata_stable", resp_rdata, 32'hCAFE_ABF0);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_release_valid", {31'd0, resp_valid}, 32'd0);
      chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
      do_access(0, SZ_W, 0, 32'h10, 0, 0, rd, er, lat, mpre, mresp);
      chk("hold_store_ignored", rd, 32'hCAFE_ABF0);

      // Reset during WAIT of a store: nothing committed, no response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h10;
      req_wdata = 32'hFFFF_FFFF; resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("midrst_in_wait", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
      chk("midrst_mmio", mmio_out, 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk("midrst_valid_held", {31'd0, resp_valid}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      do_access(0, SZ_W, 0, 32'h10, 0, 0, rd, er, lat, mpre, mresp);
      chk("midrst_ram_unchanged", rd, 32'hCAFE_ABF0);
      chk("midrst_lat", lat, WAIT + 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
